spi_cmd_queue: RTL

//  Command queue between the CPU store path and the SPI 8-bit output driver.
//  - Buffers 10-bit SPI command words written by the CPU to the SPI address.
//  - Issues the words to the driver one at a time, pacing on the driver's busy flag.
//  - Software no longer has to poll or spin-wait between display bytes.
//  - Exposes a status word on a read-only memory-mapped address.

---
 rtl/spi_cmd_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/spi_cmd_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command queue: FSM encoding, status layout
// and command-word field positions.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } cmd_state_t;

  localparam int unsigned STAT_W         = 16;
  localparam int unsigned STAT_ACTIVE    = 11;
  localparam int unsigned STAT_OVF       = 10;
  localparam int unsigned STAT_FULL      = 9;
  localparam int unsigned STAT_EMPTY     = 8;
  localparam int unsigned STAT_COUNT_MSB = 4;
  localparam int unsigned STAT_COUNT_LSB = 0;
  localparam int unsigned STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;

  // Power-on commands never raise the driver's busy flag.
  localparam int unsigned PWR_ON_BIT     = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage and a combinational head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_c,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Pointers wrap naturally because DEPTH is 2**AW.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// CPU-to-SPI command queue: buffers command words and issues them one at a
// time to the SPI driver, pacing on its busy flag; exposes a status word.
module spi_cmd_queue
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 10,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr_en,
  input  logic [DW-1:0]     wr_data,
  input  logic              clr_ovf,
  input  logic              spi_busy,
  output logic              spi_start,
  output logic [DW-1:0]     spi_din,
  output logic [STAT_W-1:0] status
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);

  cmd_state_t    r_state;
  cmd_state_t    w_state_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          w_start_nxt;
  logic [DW-1:0] w_din_nxt;
  logic          w_pop;
  logic          w_rej;
  logic [DW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  sync_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_   (reset_),
    .i_push   (wr_en),
    .i_data   (wr_data),
    .i_pop    (w_pop),
    .o_head_c (w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_ovf     <= 1'b0;
      spi_start <= 1'b0;
      spi_din   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_ovf     <= w_ovf_nxt;
      spi_start <= w_start_nxt;
      spi_din   <= w_din_nxt;
    end
  end

  // HOLD masks the driver's busy-rise latency before DRAIN starts sampling it.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_start_nxt = 1'b0;
    w_din_nxt   = spi_din;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !spi_busy) begin
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_din_nxt   = w_head;
          w_hold_nxt  = HW'(HOLD_CYC);
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_hold_nxt = r_hold - HW'(1);
        if (w_hold_nxt == '0) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!spi_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A dropped write wins over a simultaneous clear.
  assign w_rej     = wr_en && w_full && !w_pop;
  assign w_ovf_nxt = w_rej ? 1'b1 : (clr_ovf ? 1'b0 : r_ovf);

  always_comb begin
    status                                = '0;
    status[STAT_ACTIVE]                   = (r_state != ST_IDLE) || !w_empty;
    status[STAT_OVF]                      = r_ovf;
    status[STAT_FULL]                     = w_full;
    status[STAT_EMPTY]                    = w_empty;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB] = STAT_COUNT_W'(w_count);
  end

endmodule
